// File: rtl/cla_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract that reuses one 4-bit carry-lookahead slice,
// processing one nibble per clock from LSB to MSB behind a start/busy/done handshake.

module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       gout_o,
    output logic       pout_o
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    // Lookahead carries are expanded explicitly so no carry ripples through the slice.
    always_comb begin
        g_s    = a_i & b_i;
        p_s    = a_i ^ b_i;
        c_s[0] = cin_i;
        c_s[1] = g_s[0] | (p_s[0] & cin_i);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin_i);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin_i);
        gout_o = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
        pout_o = &p_s;
        c_s[4] = gout_o | (pout_o & cin_i);
        sum_o  = p_s ^ c_s[3:0];
    end
endmodule

module cla_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0]       slice_sum_s;
    logic             slice_g_s;
    logic             slice_p_s;

    cla_4bit u_slice (
        .a_i    (opa_q[{idx_q, 2'b00} +: 4]),
        .b_i    (opb_q[{idx_q, 2'b00} +: 4]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum_s),
        .gout_o (slice_g_s),
        .pout_o (slice_p_s)
    );

    // Next-state and datapath update; subtraction is a + ~b + 1 with the +1 as initial carry.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d    = a;
                    opb_d    = sub ? ~b : b;
                    carry_d  = sub;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = slice_sum_s;
                carry_d = slice_g_s | (slice_p_s & carry_q);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    cout_d  = carry_d;
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1])
                            & (result_d[WIDTH-1] != opa_q[WIDTH-1]);
                    zero_d  = (result_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Randomized bench for cla_serial_adder_ctrl against a cycle-level arithmetic model,
// plus directed cases with hand-computed results.

module tb_cla_serial_adder_ctrl;
    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic              sub   = 1'b0;
    logic [WIDTH-1:0]  a     = '0;
    logic [WIDTH-1:0]  b     = '0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              cout;
    logic              overflow;
    logic              zero;

    int n_chk  = 0;
    int n_pass = 0;

    cla_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Reference model: operation outcome from plain arithmetic, plus cycle position.
    logic              m_run = 1'b0;
    logic              m_done = 1'b0;
    int                m_cnt = 0;
    logic [WIDTH-1:0]  m_tgt = '0;
    logic              m_tcout = 1'b0;
    logic              m_tovf = 1'b0;
    logic [WIDTH-1:0]  m_res = '0;
    logic              m_cout = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_zero = 1'b0;

    function automatic logic [WIDTH-1:0] low_nibbles(input logic [WIDTH-1:0] v, input int k);
        logic [63:0] msk;
        msk = (64'd1 << (4 * k)) - 64'd1;
        return v & msk[WIDTH-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin : model
        longint sv;
        if (rst) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_run) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == NIB) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_tgt;
                m_cout <= m_tcout;
                m_ovf  <= m_tovf;
                m_zero <= (m_tgt == '0);
            end else begin
                m_res <= low_nibbles(m_tgt, m_cnt + 1);
            end
        end else if (start) begin
            if (sub) begin
                sv = longint'($signed(a)) - longint'($signed(b));
                m_tgt   <= a - b;
                m_tcout <= (a >= b);
            end else begin
                sv = longint'($signed(a)) + longint'($signed(b));
                m_tgt   <= a + b;
                m_tcout <= ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
            end
            m_tovf <= (sv > SMAX) || (sv < SMIN);
            m_run  <= 1'b1;
            m_cnt  <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // One clock, then compare every output against the model on the falling edge.
    task automatic step();
        @(negedge clk);
        chk("busy", 64'(busy), 64'(m_run));
        chk("done", 64'(done), 64'(m_done));
        chk("result", 64'(result), 64'(m_res));
        chk("cout", 64'(cout), 64'(m_cout));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("zero", 64'(zero), 64'(m_zero));
        chk("busy_done_excl", 64'(busy & done), 64'd0);
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                          input logic [31:0] er, input logic ec, input logic eo, input logic ez);
        int  lat;
        logic seen;
        a = ia; b = ib; sub = is; start = 1'b1;
        step();
        start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
        lat = 1; seen = 1'b0;
        while (!seen && lat < 30) begin
            step();
            lat++;
            if (done) seen = 1'b1;
        end
        chk("done_timeout", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(NIB + 1));
        chk("lit_result", 64'(result), 64'(er));
        chk("lit_cout", 64'(cout), 64'(ec));
        chk("lit_overflow", 64'(overflow), 64'(eo));
        chk("lit_zero", 64'(zero), 64'(ez));
        step();
    endtask

    initial begin
        int ndone;
        repeat (2) step();
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();

        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);

        // start held high: accepts only from IDLE, every NIB+2 cycles.
        ndone = 0;
        start = 1'b1;
        repeat (40) begin
            a = $urandom; b = $urandom; sub = 1'($urandom);
            step();
            if (done) ndone++;
        end
        start = 1'b0;
        chk("hold_done_count", 64'(ndone), 64'd4);
        repeat (2) step();

        // Async reset in the third RUN cycle.
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_result", 64'(result), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        step();
        rst = 1'b0;
        repeat (NIB + 2) begin
            step();
            chk("rst_no_done", 64'(done), 64'd0);
        end
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        repeat (5) begin
            step();
            chk("held_done", 64'(done), 64'd0);
        end
        chk("held_result", 64'(result), 64'd0);
        chk("held_ovf", 64'(overflow), 64'd1);
        chk("held_cout", 64'(cout), 64'd1);
        chk("held_zero", 64'(zero), 64'd1);

        // Random traffic, including start pulses that land in RUN/DONE.
        repeat (600) begin
            start = ($urandom % 3 == 0);
            a = $urandom; b = $urandom; sub = 1'($urandom);
            if ($urandom % 8 == 0) b = a;
            step();
        end
        start = 1'b0;
        repeat (NIB + 3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cla_serial_adder_ctrl.md
Name: cla_serial_adder_ctrl

Overview:
- Multi-cycle add/subtract controller that time-shares one 4-bit CLA slice (cla_4bit instance, group gout/pout outputs) across all nibbles of a WIDTH-bit operand pair, LSB nibble first.
- Area-reduced ALU adder path for the mini-RISC datapath.
- Uses a start/busy/done handshake toward the control unit, and produces result, carry, overflow and zero flags.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, nibble count (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  sum/difference register.
- cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, nibble index=0, carry=0.
  - Operand registers, result, cout, overflow and zero all 0; busy=0, done=0.
  - An in-flight operation is discarded and produces no done pulse.
- IDLE:
  - On the edge where start=1:
    - latch opA=a and opB=(sub ? ~b : b);
    - carry=sub, index=0, result=0, overflow=0, zero=0, cout=0;
    - go to RUN.
  - start=0 holds all outputs, so the previous result and flags remain readable.
- RUN, each edge:
  - Drive the slice with opA/opB nibble[index] and cin=carry.
  - Write slice sum to result nibble[index].
  - Update carry = gout | (pout & carry).
  - If index==NIB-1, go to DONE; otherwise index+1.
- DONE entry (same edge as the last nibble write):
  - cout = final carry.
  - overflow = (opA[MSB]==opB[MSB]) & (new result[MSB]!=opA[MSB]).
  - zero = (full new result == 0).
- DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
- Latency: the start edge is E0. Nibbles are written on E1..E_NIB. done is high from E_NIB to E_NIB+1. For WIDTH=32 this is an 8-cycle gap from start sample to done.
- busy:
  - high for exactly NIB cycles;
  - low in IDLE and DONE;
  - busy and done are never high together.
- start in RUN or DONE is ignored and not queued. No back-to-back issue: the next start is accepted in IDLE, the earliest being one cycle after done.
- a, b and sub may change freely after the start edge; only the latched values are used.
- result bits are intermediate during RUN and valid only from the done cycle until the next accepted start.
- All arithmetic is modulo 2^WIDTH. The slice is purely combinational; all state lives in this block.

Test Plan:
- WIDTH=32, a=0x0000_0001, b=0xFFFF_FFFF, sub=0, start pulse -> 8 busy cycles; done pulse; result=0x0000_0000, cout=1, zero=1, overflow=0.
- a=0x7FFF_FFFF, b=0x0000_0001, sub=0 -> result=0x8000_0000, overflow=1, cout=0, zero=0. The carry ripples through all 8 nibble steps.
- a=5, b=7, sub=1 -> result=0xFFFF_FFFE, cout=0 (borrow), overflow=0. Then a=7, b=5, sub=1 -> result=0x0000_0002, cout=1.
- Hold start=1 continuously with changing a/b:
  - operations accepted only on IDLE edges, exactly NIB+2 cycles apart (E0, E_NIB+2, ...);
  - each result matches the a/b sampled at its accept edge;
  - busy/done timing as specified.
- Assert rst during the 3rd RUN cycle of a=0x1234_5678 + b=0x1111_1111 -> immediately all outputs 0 and state IDLE, no done pulse. A new start after release gives result=0x2345_6789 with standard latency.
- a=0x8000_0000, b=0x8000_0000, sub=0 -> result=0, cout=1, overflow=1, zero=1. Then start=0 for 5 cycles -> result and flags held, done stays 0.
